// File: rtl/udp_pkg.sv
// Shared types for the UDP transmit path: the 96-bit transmit header and
// the arbiter FSM state encoding.
package udp_pkg;

    localparam int HDR_W = 96;

    typedef struct packed {
        logic [31:0] dest_ip;
        logic [15:0] source_port;
        logic [15:0] dest_port;
        logic [15:0] length;
        logic [15:0] checksum;
    } udp_tx_hdr_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_priority_select.sv
// Combinational circular priority search: first asserted request starting
// one position after last_grant, wrapping modulo NUM_PORTS.
module rr_priority_select #(
    parameter int NUM_PORTS = 2,
    localparam int IDX_W = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     last_grant,
    output logic [IDX_W-1:0]     grant,
    output logic                 any_request
);

    logic             found;
    logic [IDX_W-1:0] idx;

    always_comb begin
        grant       = '0;
        found       = 1'b0;
        idx         = '0;
        any_request = |req;
        // i runs 1..NUM_PORTS so last_grant itself is checked last
        for (int i = 1; i <= NUM_PORTS; i++) begin
            idx = IDX_W'((int'(last_grant) + i) % NUM_PORTS);
            if (!found && req[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Round-robin arbiter that lets NUM_PORTS requesters share one UDP stack
// transmit input; a grant covers one header plus its payload up to tlast.
module udp_tx_arbiter
    import udp_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = 8,
    localparam int IDX_W = $clog2(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            s_hdr_valid,
    output logic [NUM_PORTS-1:0]            s_hdr_ready,
    input  logic [NUM_PORTS*HDR_W-1:0]      s_hdr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_PORTS-1:0]            s_tvalid,
    output logic [NUM_PORTS-1:0]            s_tready,
    input  logic [NUM_PORTS-1:0]            s_tlast,
    input  logic [NUM_PORTS-1:0]            s_tuser,
    output logic                            m_hdr_valid,
    input  logic                            m_hdr_ready,
    output logic [HDR_W-1:0]                m_hdr,
    output logic [DATA_WIDTH-1:0]           m_tdata,
    output logic                            m_tvalid,
    input  logic                            m_tready,
    output logic                            m_tlast,
    output logic                            m_tuser,
    output logic [IDX_W-1:0]                active_port,
    output logic                            active,
    output arb_state_t                      state
);

    // Handshakes: a transfer happens on a clock edge where valid and ready
    // are both high; valid never waits on ready, ready may depend on valid.
    arb_state_t             state_q, state_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic [IDX_W-1:0]       last_grant_q, last_grant_d;
    logic [IDX_W-1:0]       rr_grant;
    logic                   rr_any;
    logic [HDR_W-1:0]       sel_hdr;
    logic [DATA_WIDTH-1:0]  sel_tdata;

    rr_priority_select #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr (
        .req         (s_hdr_valid),
        .last_grant  (last_grant_q),
        .grant       (rr_grant),
        .any_request (rr_any)
    );

    assign sel_hdr   = s_hdr[int'(grant_q)*HDR_W +: HDR_W];
    assign sel_tdata = s_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NUM_PORTS - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        s_hdr_ready  = '0;
        s_tready     = '0;
        m_hdr_valid  = 1'b0;
        m_hdr        = '0;
        m_tdata      = '0;
        m_tvalid     = 1'b0;
        m_tlast      = 1'b0;
        m_tuser      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (rr_any) begin
                    grant_d = rr_grant;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                m_hdr_valid          = s_hdr_valid[grant_q];
                m_hdr                = sel_hdr;
                s_hdr_ready[grant_q] = m_hdr_ready;
                if (s_hdr_valid[grant_q] && m_hdr_ready) begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                m_tdata           = sel_tdata;
                m_tvalid          = s_tvalid[grant_q];
                m_tlast           = s_tlast[grant_q];
                m_tuser           = s_tuser[grant_q];
                s_tready[grant_q] = m_tready;
                // tuser is carried through; only tlast releases the grant
                if (s_tvalid[grant_q] && m_tready && s_tlast[grant_q]) begin
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign active      = (state_q != ST_IDLE);
    assign active_port = grant_q;
    assign state       = state_q;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed bench for udp_tx_arbiter with three requesters: per-port packet
// sources, a sink monitor with expected grant queue, and reset scenarios.
module tb_udp_tx_arbiter;
    import udp_pkg::*;

    localparam int NP   = 3;
    localparam int DW   = 8;
    localparam int IW   = $clog2(NP);
    localparam int MAXP = 4;
    localparam int MAXB = 8;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [NP-1:0]        s_hdr_valid;
    logic [NP-1:0]        s_hdr_ready;
    logic [NP*HDR_W-1:0]  s_hdr;
    logic [NP*DW-1:0]     s_tdata;
    logic [NP-1:0]        s_tvalid;
    logic [NP-1:0]        s_tready;
    logic [NP-1:0]        s_tlast;
    logic [NP-1:0]        s_tuser;
    logic                 m_hdr_valid;
    logic                 m_hdr_ready;
    logic [HDR_W-1:0]     m_hdr;
    logic [DW-1:0]        m_tdata;
    logic                 m_tvalid;
    logic                 m_tready;
    logic                 m_tlast;
    logic                 m_tuser;
    logic [IW-1:0]        active_port;
    logic                 active;
    arb_state_t           dut_state;

    int n_checks = 0;
    int n_fail   = 0;

    // packet store and source/monitor bookkeeping
    logic [7:0]  pkt_data [NP][MAXP][MAXB];
    logic        pkt_user [NP][MAXP][MAXB];
    logic [95:0] pkt_hdr  [NP][MAXP];
    int          pkt_len  [NP][MAXP];
    int          pkt_cnt  [NP];
    int          src_pkt  [NP];
    int          src_byte [NP];
    bit          src_pay  [NP];
    int          mon_pkt  [NP];
    logic [IW-1:0] exp_q[$];
    int          first_hdr_cycle;

    udp_tx_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .s_hdr_valid (s_hdr_valid),
        .s_hdr_ready (s_hdr_ready),
        .s_hdr       (s_hdr),
        .s_tdata     (s_tdata),
        .s_tvalid    (s_tvalid),
        .s_tready    (s_tready),
        .s_tlast     (s_tlast),
        .s_tuser     (s_tuser),
        .m_hdr_valid (m_hdr_valid),
        .m_hdr_ready (m_hdr_ready),
        .m_hdr       (m_hdr),
        .m_tdata     (m_tdata),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .m_tlast     (m_tlast),
        .m_tuser     (m_tuser),
        .active_port (active_port),
        .active      (active),
        .state       (dut_state)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        s_hdr_valid = '0;
        s_hdr       = '0;
        s_tdata     = '0;
        s_tvalid    = '0;
        s_tlast     = '0;
        s_tuser     = '0;
        m_hdr_ready = 1'b0;
        m_tready    = 1'b0;
    endtask

    task automatic apply_reset(input int cycles);
        reset = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic clear_pkts();
        for (int p = 0; p < NP; p++) begin
            pkt_cnt[p]  = 0;
            src_pkt[p]  = 0;
            src_byte[p] = 0;
            src_pay[p]  = 1'b0;
            mon_pkt[p]  = 0;
        end
        exp_q.delete();
    endtask

    task automatic add_pkt(input int p, input int len, input logic [7:0] base);
        udp_tx_hdr_t h;
        int k;
        k = pkt_cnt[p];
        h.dest_ip     = 32'h0A00_0000 + 32'(p * 256 + k);
        h.source_port = 16'h1000 + 16'(p);
        h.dest_port   = 16'h2000 + 16'(k);
        h.length      = 16'(8 + len);
        h.checksum    = 16'hBEE0 + 16'(p);
        pkt_hdr[p][k] = h;
        pkt_len[p][k] = len;
        for (int i = 0; i < MAXB; i++) begin
            pkt_data[p][k][i] = base + 8'(i);
            pkt_user[p][k][i] = (i == 1);
        end
        pkt_cnt[p] = k + 1;
    endtask

    // Sources present their packets cycle by cycle; the monitor checks the
    // master side against the expected grant queue and the packet store.
    task automatic run_traffic(input int budget, input bit toggle_ready);
        int  cyc;
        int  exp_port;
        int  mon_byte;
        int  k;
        bit  mon_in_pkt;
        bit  prev_last;
        bit  bad;
        cyc        = 0;
        exp_port   = 0;
        mon_byte   = 0;
        mon_in_pkt = 1'b0;
        prev_last  = 1'b0;
        first_hdr_cycle = -1;
        while ((exp_q.size() != 0 || mon_in_pkt) && cyc < budget) begin
            idle_inputs();
            for (int p = 0; p < NP; p++) begin
                if (src_pkt[p] < pkt_cnt[p]) begin
                    k = src_pkt[p];
                    s_hdr[p*HDR_W +: HDR_W] = pkt_hdr[p][k];
                    if (!src_pay[p]) begin
                        s_hdr_valid[p] = 1'b1;
                    end else begin
                        s_tvalid[p]         = 1'b1;
                        s_tdata[p*DW +: DW] = pkt_data[p][k][src_byte[p]];
                        s_tlast[p]          = (src_byte[p] == pkt_len[p][k] - 1);
                        s_tuser[p]          = pkt_user[p][k][src_byte[p]];
                    end
                end
            end
            m_hdr_ready = 1'b1;
            m_tready    = toggle_ready ? (cyc % 2 == 0) : 1'b1;
            #1;
            bad = 1'b0;
            for (int p = 0; p < NP; p++) begin
                if ((!active || int'(active_port) != p) && (s_hdr_ready[p] || s_tready[p]))
                    bad = 1'b1;
            end
            n_checks++;
            if (bad) begin
                n_fail++;
                $display("FAIL ready_isolation cyc=%0d: hdr_ready=%b tready=%b active=%b port=%0d",
                         cyc, s_hdr_ready, s_tready, active, active_port);
            end
            if (prev_last) begin
                n_checks++;
                if (active !== 1'b0 || m_hdr_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL idle_gap cyc=%0d: active=%b m_hdr_valid=%b, required 0/0",
                             cyc, active, m_hdr_valid);
                end
            end
            prev_last = 1'b0;
            if (m_hdr_valid && m_hdr_ready) begin
                if (first_hdr_cycle < 0) first_hdr_cycle = cyc;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_hdr cyc=%0d: port=%0d, no grant expected", cyc, active_port);
                end else begin
                    exp_port = int'(exp_q.pop_front());
                    if (int'(active_port) !== exp_port) begin
                        n_fail++;
                        $display("FAIL grant_order cyc=%0d: port=%0d required %0d", cyc, active_port, exp_port);
                    end
                    n_checks++;
                    if (m_hdr !== pkt_hdr[exp_port][mon_pkt[exp_port]]) begin
                        n_fail++;
                        $display("FAIL hdr_data cyc=%0d: got %h required %h", cyc, m_hdr,
                                 pkt_hdr[exp_port][mon_pkt[exp_port]]);
                    end
                    mon_in_pkt = 1'b1;
                    mon_byte   = 0;
                end
            end else if (m_tvalid && m_tready) begin
                n_checks++;
                if (!mon_in_pkt) begin
                    n_fail++;
                    $display("FAIL beat_before_hdr cyc=%0d: data=%h", cyc, m_tdata);
                end else begin
                    k = mon_pkt[exp_port];
                    if (m_tdata !== pkt_data[exp_port][k][mon_byte] ||
                        m_tuser !== pkt_user[exp_port][k][mon_byte] ||
                        m_tlast !== (mon_byte == pkt_len[exp_port][k] - 1)) begin
                        n_fail++;
                        $display("FAIL beat cyc=%0d port=%0d byte=%0d: got d=%h u=%b l=%b required d=%h u=%b l=%b",
                                 cyc, exp_port, mon_byte, m_tdata, m_tuser, m_tlast,
                                 pkt_data[exp_port][k][mon_byte], pkt_user[exp_port][k][mon_byte],
                                 (mon_byte == pkt_len[exp_port][k] - 1));
                    end
                    if (mon_byte == pkt_len[exp_port][k] - 1) begin
                        mon_pkt[exp_port]++;
                        mon_in_pkt = 1'b0;
                        prev_last  = 1'b1;
                    end
                    mon_byte++;
                end
            end
            for (int p = 0; p < NP; p++) begin
                if (s_hdr_valid[p] && s_hdr_ready[p]) src_pay[p] = 1'b1;
                if (s_tvalid[p] && s_tready[p]) begin
                    if (s_tlast[p]) begin
                        src_pkt[p]++;
                        src_pay[p]  = 1'b0;
                        src_byte[p] = 0;
                    end else begin
                        src_byte[p]++;
                    end
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        n_checks++;
        if (exp_q.size() != 0 || mon_in_pkt) begin
            n_fail++;
            $display("FAIL traffic_timeout: %0d grants outstanding, in_pkt=%b after %0d cycles",
                     exp_q.size(), mon_in_pkt, cyc);
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        s_hdr_valid = '1;
        apply_reset(3);
        // reset has just been released; outputs reflect the reset state
        n_checks++;
        if (dut_state !== ST_IDLE || active !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d active=%b required IDLE/0", dut_state, active);
        end
        n_checks++;
        if (m_hdr_valid !== 1'b0 || m_tvalid !== 1'b0 || s_hdr_ready !== '0 || s_tready !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: m_hdr_valid=%b m_tvalid=%b s_hdr_ready=%b s_tready=%b required all 0",
                     m_hdr_valid, m_tvalid, s_hdr_ready, s_tready);
        end
        s_hdr_valid = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_simultaneous();
        clear_pkts();
        add_pkt(0, 3, 8'h10);
        add_pkt(1, 2, 8'h20);
        exp_q.push_back(IW'(0));
        exp_q.push_back(IW'(1));
        run_traffic(100, 1'b0);
    endtask

    task automatic test_single_port1();
        clear_pkts();
        add_pkt(1, 4, 8'h00);
        pkt_data[1][0][0] = 8'hDE;
        pkt_data[1][0][1] = 8'hAD;
        pkt_data[1][0][2] = 8'hBE;
        pkt_data[1][0][3] = 8'hEF;
        exp_q.push_back(IW'(1));
        run_traffic(100, 1'b0);
        n_checks++;
        if (first_hdr_cycle !== 1) begin
            n_fail++;
            $display("FAIL arb_latency: header valid at cycle %0d required 1", first_hdr_cycle);
        end
    endtask

    task automatic test_round_robin();
        idle_inputs();
        apply_reset(1);
        clear_pkts();
        for (int r = 0; r < 2; r++) begin
            add_pkt(0, 2, 8'h30 + 8'(r * 8));
            add_pkt(1, 3, 8'h50 + 8'(r * 8));
            add_pkt(2, 1, 8'h70 + 8'(r * 8));
        end
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(IW'(0));
            exp_q.push_back(IW'(1));
            exp_q.push_back(IW'(2));
        end
        run_traffic(300, 1'b0);
    endtask

    task automatic test_tready_toggle();
        clear_pkts();
        add_pkt(1, 5, 8'h90);
        add_pkt(2, 4, 8'hA0);
        // last grant is 2 after the rotation, so port 1 is next
        exp_q.push_back(IW'(1));
        exp_q.push_back(IW'(2));
        run_traffic(200, 1'b1);
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        apply_reset(2);
        s_hdr_valid[2]      = 1'b1;
        s_hdr[2*HDR_W +: HDR_W] = 96'h0A000002_1002_2000_000E_BEE2;
        s_tvalid[2]         = 1'b1;
        s_tdata[2*DW +: DW] = 8'h55;
        m_hdr_ready         = 1'b1;
        m_tready            = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 8'h55 || active_port !== IW'(2)) begin
            n_fail++;
            $display("FAIL mid_payload: m_tvalid=%b data=%h port=%0d required 1/55/2",
                     m_tvalid, m_tdata, active_port);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset       = 1'b1;
        s_hdr_valid = 3'b110;
        #1;
        n_checks++;
        if (active !== 1'b0 || m_tvalid !== 1'b0 || m_hdr_valid !== 1'b0 ||
            s_tready !== '0 || s_hdr_ready !== '0) begin
            n_fail++;
            $display("FAIL reset_abandon: active=%b m_tvalid=%b m_hdr_valid=%b s_tready=%b s_hdr_ready=%b required all 0",
                     active, m_tvalid, m_hdr_valid, s_tready, s_hdr_ready);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (active !== 1'b1 || active_port !== IW'(1) || m_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_grant: active=%b port=%0d m_tvalid=%b required 1/1/0",
                     active, active_port, m_tvalid);
        end
        idle_inputs();
        apply_reset(1);
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_simultaneous();
        test_single_port1();
        test_round_robin();
        test_tready_toggle();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
